// File: rtl/calc_pkg.sv
// Shared keycode map, ALU opcode encoding and sequencer state type.
package calc_pkg;

  localparam logic [4:0] KeyEq  = 5'b00100;
  localparam logic [4:0] KeyAdd = 5'b01010;
  localparam logic [4:0] KeyMul = 5'b00010;
  localparam logic [4:0] KeySub = 5'b00011;
  localparam logic [4:0] KeyClr = 5'b00001;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpMul = 2'b01;
  localparam logic [1:0] OpSub = 2'b10;

  typedef enum logic [2:0] {
    StEntryA,
    StEntryB,
    StIssue,
    StWaitRes,
    StShowRes
  } state_e;

endpackage

// File: rtl/keycode_decode.sv
// Combinational keycode classifier: hex digit, operator, equals or clear.
module keycode_decode
  import calc_pkg::*;
#(
  parameter int unsigned KEYW = 5
) (
  input  logic [KEYW-1:0] keycode,
  output logic            is_hex,
  output logic [3:0]      hex,
  output logic            is_op,
  output logic [1:0]      op,
  output logic            is_eq,
  output logic            is_clr
);

  logic [4:0] key5;
  assign key5 = keycode[4:0];

  always_comb begin
    is_hex = key5[4];
    hex    = key5[3:0];
    is_op  = 1'b0;
    op     = OpAdd;
    is_eq  = 1'b0;
    is_clr = 1'b0;
    if (!key5[4]) begin
      case (key5)
        KeyAdd: begin
          is_op = 1'b1;
          op    = OpAdd;
        end
        KeyMul: begin
          is_op = 1'b1;
          op    = OpMul;
        end
        KeySub: begin
          is_op = 1'b1;
          op    = OpSub;
        end
        KeyEq:   is_eq  = 1'b1;
        KeyClr:  is_clr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_sequencer.sv
// Operand-entry sequencer: builds hex operands from key presses, hands them
// to the ALU over valid/ready and feeds the result back as the next A.
module keypad_entry_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned KEYW   = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                newkey,
  input  logic [KEYW-1:0]     keycode,
  output logic                calc_valid,
  input  logic                calc_ready,
  output logic [4*DIGITS-1:0] operand_a,
  output logic [4*DIGITS-1:0] operand_b,
  output logic [1:0]          opcode,
  input  logic                result_valid,
  input  logic [4*DIGITS-1:0] result,
  output logic [4*DIGITS-1:0] display,
  output logic                overflow,
  output logic                busy
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic       key_is_hex, key_is_op, key_is_eq, key_is_clr;
  logic [3:0] key_hex;
  logic [1:0] key_op;

  keycode_decode #(
    .KEYW(KEYW)
  ) u_decode (
    .keycode(keycode),
    .is_hex (key_is_hex),
    .hex    (key_hex),
    .is_op  (key_is_op),
    .op     (key_op),
    .is_eq  (key_is_eq),
    .is_clr (key_is_clr)
  );

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, display_q, display_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic           calc_valid_q, calc_valid_d;
  logic           full;

  assign full = (count_q >= CW'(DIGITS));

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    calc_valid_d = calc_valid_q;

    if (newkey && key_is_clr) begin
      state_d      = StEntryA;
      a_d          = '0;
      b_d          = '0;
      op_d         = OpAdd;
      count_d      = '0;
      overflow_d   = 1'b0;
      calc_valid_d = 1'b0;
    end else begin
      case (state_q)
        StEntryA: begin
          if (newkey && key_is_hex) begin
            if (!full) begin
              a_d     = {a_q[W-5:0], key_hex};
              count_d = count_q + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else if (newkey && key_is_op) begin
            op_d    = key_op;
            b_d     = '0;
            count_d = '0;
            state_d = StEntryB;
          end
        end
        StEntryB: begin
          if (newkey && key_is_hex) begin
            if (!full) begin
              b_d     = {b_q[W-5:0], key_hex};
              count_d = count_q + CW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end else if (newkey && key_is_op) begin
            op_d = key_op;
          end else if (newkey && key_is_eq && (count_q != '0)) begin
            state_d      = StIssue;
            calc_valid_d = 1'b1;
          end
        end
        StIssue: begin
          if (calc_valid_q && calc_ready) begin
            state_d      = StWaitRes;
            calc_valid_d = 1'b0;
          end
        end
        StWaitRes: begin
          if (result_valid) begin
            a_d        = result;
            overflow_d = 1'b0;
            state_d    = StShowRes;
          end
        end
        StShowRes: begin
          if (newkey && key_is_hex) begin
            a_d     = {{(W - 4){1'b0}}, key_hex};
            b_d     = '0;
            count_d = CW'(1);
            state_d = StEntryA;
          end else if (newkey && key_is_op) begin
            op_d    = key_op;
            b_d     = '0;
            count_d = '0;
            state_d = StEntryB;
          end
        end
        default: state_d = StEntryA;
      endcase
    end

    // Display is registered, so derive it from next-state values.
    case (state_d)
      StEntryB:            display_d = (count_d == '0) ? a_d : b_d;
      StIssue, StWaitRes:  display_d = b_d;
      default:             display_d = a_d;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StEntryA;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OpAdd;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      calc_valid_q <= 1'b0;
      display_q    <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      calc_valid_q <= calc_valid_d;
      display_q    <= display_d;
    end
  end

  assign calc_valid = calc_valid_q;
  assign operand_a  = a_q;
  assign operand_b  = b_q;
  assign opcode     = op_q;
  assign display    = display_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == StIssue) || (state_q == StWaitRes);

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
// Directed bench for keypad_entry_sequencer with hand-computed expectations.
module tb_keypad_entry_sequencer;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned KEYW   = 5;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         newkey;
  logic [4:0]   keycode;
  logic         calc_valid;
  logic         calc_ready;
  logic [W-1:0] operand_a, operand_b, result, display;
  logic [1:0]   opcode;
  logic         result_valid;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  keypad_entry_sequencer #(
    .DIGITS(DIGITS),
    .KEYW  (KEYW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .newkey      (newkey),
    .keycode     (keycode),
    .calc_valid  (calc_valid),
    .calc_ready  (calc_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .opcode      (opcode),
    .result_valid(result_valid),
    .result      (result),
    .display     (display),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (calc_valid && calc_ready) xfers++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one key for one edge; returns at the following falling edge.
  task automatic press(input logic [4:0] k);
    @(negedge clock);
    newkey  = 1'b1;
    keycode = k;
    @(negedge clock);
    newkey  = 1'b0;
    keycode = 5'b0;
  endtask

  task automatic pulse_result(input logic [W-1:0] r);
    @(negedge clock);
    result_valid = 1'b1;
    result       = r;
    @(negedge clock);
    result_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    newkey       = 1'b0;
    keycode      = 5'b0;
    calc_ready   = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    #12;
    check("rst_display", 32'(display), 32'h0);
    check("rst_valid", 32'(calc_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_a", 32'(operand_a), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1 2 + 3 = with ready high
    calc_ready = 1'b1;
    press(5'h11);
    press(5'h12);
    check("entry_disp_a", 32'(display), 32'h12);
    press(5'h0A);
    check("entry_disp_b0", 32'(display), 32'h12);
    press(5'h13);
    check("entry_disp_b", 32'(display), 32'h3);
    press(5'h04);
    check("iss_valid", 32'(calc_valid), 32'h1);
    check("iss_a", 32'(operand_a), 32'h12);
    check("iss_b", 32'(operand_b), 32'h3);
    check("iss_op", 32'(opcode), 32'h0);
    check("iss_busy", 32'(busy), 32'h1);
    @(negedge clock);
    check("acc_valid", 32'(calc_valid), 32'h0);
    check("acc_busy", 32'(busy), 32'h1);
    check("acc_xfers", 32'(xfers), 32'h1);
    pulse_result(16'h0015);
    check("res_disp", 32'(display), 32'h15);
    check("res_busy", 32'(busy), 32'h0);

    // Chain: * 2 = with ready held low
    press(5'h02);
    check("chain_disp", 32'(display), 32'h15);
    press(5'h12);
    check("chain_disp_b", 32'(display), 32'h2);
    calc_ready = 1'b0;
    press(5'h04);
    check("chain_valid", 32'(calc_valid), 32'h1);
    check("chain_a", 32'(operand_a), 32'h15);
    check("chain_b", 32'(operand_b), 32'h2);
    check("chain_op", 32'(opcode), 32'h1);
    press(5'h17);
    press(5'h18);
    repeat (3) @(negedge clock);
    check("hold_valid", 32'(calc_valid), 32'h1);
    check("hold_a", 32'(operand_a), 32'h15);
    check("hold_b", 32'(operand_b), 32'h2);
    check("hold_disp", 32'(display), 32'h2);
    check("hold_xfers", 32'(xfers), 32'h1);
    calc_ready = 1'b1;
    @(negedge clock);
    check("hs_xfers", 32'(xfers), 32'h2);
    check("hs_valid", 32'(calc_valid), 32'h0);
    @(negedge clock);
    check("hs_once", 32'(xfers), 32'h2);

    // Digit and result on the same edge in WAIT_RES: result wins
    @(negedge clock);
    newkey       = 1'b1;
    keycode      = 5'h13;
    result_valid = 1'b1;
    result       = 16'h002A;
    @(negedge clock);
    newkey       = 1'b0;
    result_valid = 1'b0;
    check("sim_disp", 32'(display), 32'h2A);
    check("sim_a", 32'(operand_a), 32'h2A);
    check("sim_b", 32'(operand_b), 32'h2);
    check("sim_busy", 32'(busy), 32'h0);

    press(5'h01);
    check("clr_a", 32'(operand_a), 32'h0);
    check("clr_disp", 32'(display), 32'h0);

    // Overflow on the fifth digit
    for (int i = 1; i <= 5; i++) press(5'(5'h10 + i));
    check("ovf_a", 32'(operand_a), 32'h1234);
    check("ovf_flag", 32'(overflow), 32'h1);
    check("ovf_disp", 32'(display), 32'h1234);
    press(5'h01);
    check("ovf_clr_a", 32'(operand_a), 32'h0);
    check("ovf_clr_flag", 32'(overflow), 32'h0);

    // Guards: equals with no B digit, then operator replacement
    press(5'h11);
    press(5'h0A);
    press(5'h04);
    check("grd_valid", 32'(calc_valid), 32'h0);
    check("grd_busy", 32'(busy), 32'h0);
    check("grd_disp", 32'(display), 32'h1);
    press(5'h03);
    press(5'h14);
    check("grd_disp_b", 32'(display), 32'h4);
    calc_ready = 1'b0;
    press(5'h04);
    check("grd_op", 32'(opcode), 32'h2);
    check("grd_valid2", 32'(calc_valid), 32'h1);
    check("grd_b", 32'(operand_b), 32'h4);
    calc_ready = 1'b1;
    @(negedge clock);
    check("wr_busy", 32'(busy), 32'h1);

    // Asynchronous reset mid-WAIT_RES
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_a", 32'(operand_a), 32'h0);
    check("arst_b", 32'(operand_b), 32'h0);
    check("arst_disp", 32'(display), 32'h0);
    check("arst_op", 32'(opcode), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    pulse_result(16'hBEEF);
    check("post_rst_a", 32'(operand_a), 32'h0);
    check("post_rst_disp", 32'(display), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);

    // Undefined keycode 00111 is ignored
    press(5'h15);
    press(5'h07);
    check("undef_disp_a", 32'(display), 32'h5);
    check("undef_a", 32'(operand_a), 32'h5);
    press(5'h0A);
    press(5'h07);
    press(5'h16);
    check("undef_disp_b", 32'(display), 32'h6);
    check("undef_b", 32'(operand_b), 32'h6);
    check("undef_busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
